// File: rtl/issue_ctrl_if.sv
// Instruction input handshake for issue_ctrl.
// valid/ready: a transfer happens on a rising edge where in_valid && in_ready; in_instr must be stable while in_valid is high.
interface issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/issue_ctrl.sv
// Instruction issue controller: FIFO of 18-bit instructions feeding a two-state
// issue FSM that drives register-file, ALU and writeback-mux control lines.
module issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  issue_ctrl_if.slave in_if,
  output logic [2:0]  opcode,
  output logic [2:0]  adr1,
  output logic [2:0]  adr2,
  output logic [2:0]  adr3,
  output logic        write,
  output logic        read2,
  output logic        read3,
  output logic        select,
  output logic [11:0] dat,
  output logic        busy,
  output logic [7:0]  retired,
  output logic        dbg_state_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  adr1;
    logic [2:0]  adr2;
    logic [2:0]  adr3;
    logic        write;
    logic        read2;
    logic        read3;
    logic        select;
    logic [11:0] dat;
  } ctrl_t;

  logic [17:0]     mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [7:0]      retired_q, retired_d;

  logic        push, pop, fifo_empty, last_cyc, head_mul;
  logic [17:0] head;

  function automatic ctrl_t decode(input logic [17:0] ins);
    ctrl_t c;
    c        = '0;
    c.opcode = ins[17:15];
    c.adr1   = ins[14:12];
    if (ins[17:15] == 3'b000) begin
      c.select = 1'b1;
      c.dat    = ins[11:0];
    end else begin
      c.read2 = 1'b1;
      c.read3 = 1'b1;
      c.adr2  = ins[11:9];
      c.adr3  = ins[8:6];
    end
    return c;
  endfunction

  assign in_if.in_ready = !rst && (count_q != CNTW'(DEPTH));
  assign push       = in_if.in_valid && in_if.in_ready;
  assign fifo_empty = (count_q == '0);
  assign last_cyc   = (state_q == EXEC) && (cnt_q == '0);
  assign pop        = !fifo_empty && ((state_q == IDLE) || last_cyc);
  assign head       = mem_q[rd_ptr_q];
  assign head_mul   = (head[17:15] == 3'b011) || (head[17:15] == 3'b100) ||
                      (head[17:15] == 3'b110);

  // Occupancy is the only full/empty indicator; pointers just wrap.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // State register (with the registered control lines it drives).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = EXEC;
      EXEC:    if (cnt_q == '0 && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs: a pop loads a fresh instruction,
  // a running multi-cycle op holds its lines and raises write on its last cycle.
  always_comb begin
    ctrl_d    = '0;
    cnt_d     = '0;
    retired_d = last_cyc ? retired_q + 8'd1 : retired_q;
    if (pop) begin
      ctrl_d = decode(head);
      if (head_mul) begin
        cnt_d        = CW'(MUL_LAT - 1);
        ctrl_d.write = (MUL_LAT == 1);
      end else begin
        ctrl_d.write = 1'b1;
      end
    end else if (state_q == EXEC && cnt_q != '0) begin
      ctrl_d       = ctrl_q;
      cnt_d        = cnt_q - CW'(1);
      ctrl_d.write = (cnt_q == CW'(1));
    end
  end

  assign opcode      = ctrl_q.opcode;
  assign adr1        = ctrl_q.adr1;
  assign adr2        = ctrl_q.adr2;
  assign adr3        = ctrl_q.adr3;
  assign write       = ctrl_q.write;
  assign read2       = ctrl_q.read2;
  assign read3       = ctrl_q.read3;
  assign select      = ctrl_q.select;
  assign dat         = ctrl_q.dat;
  assign retired     = retired_q;
  assign busy        = (state_q == EXEC) || !fifo_empty;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: table-driven single-instruction vectors,
// hand-written multi-cycle sequences, and an issue-order scoreboard on write.
module tb_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;

  typedef logic [26:0] rec_t;
  typedef struct {
    logic [17:0] instr;
    rec_t        exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode, adr1, adr2, adr3;
  logic        write, read2, read3, select, busy, dbg_state;
  logic [11:0] dat;
  logic [7:0]  retired;
  rec_t        obs;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_ret = 0;
  rec_t exp_q[$];

  issue_ctrl_if in_if();

  issue_ctrl #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_if(in_if),
    .opcode(opcode), .adr1(adr1), .adr2(adr2), .adr3(adr3),
    .write(write), .read2(read2), .read3(read3), .select(select),
    .dat(dat), .busy(busy), .retired(retired), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign obs = {opcode, adr1, adr2, adr3, read2, read3, select, dat};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t pk(input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2,
                              input logic [2:0] a3, input logic r2, input logic r3,
                              input logic sel, input logic [11:0] d);
    return {op, a1, a2, a3, r2, r3, sel, d};
  endfunction

  function automatic rec_t model(input logic [17:0] ins);
    if (ins[17:15] == 3'b000) return pk(3'b000, ins[14:12], 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, ins[11:0]);
    return pk(ins[17:15], ins[14:12], ins[11:9], ins[8:6], 1'b1, 1'b1, 1'b0, 12'h000);
  endfunction

  function automatic logic [17:0] ldi(input logic [2:0] rd, input logic [11:0] imm);
    return {3'b000, rd, imm};
  endfunction

  function automatic logic [17:0] alu(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [5:0] junk);
    return {op, rd, rs1, rs2, junk};
  endfunction

  // scoreboard: every write pulse must match the oldest expected record
  always @(negedge clk) begin
    if (rst === 1'b0 && write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got rec %0h expected no write", obs);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("sb_issue", obs, e);
      end
    end
  end

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic send(input logic [17:0] ins, input rec_t exp, input bit sb, output int stalls);
    stalls = 0;
    in_if.in_valid = 1'b1;
    in_if.in_instr = ins;
    @(negedge clk);
    while (in_if.in_ready !== 1'b1 && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (in_if.in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready %0b expected 1", in_if.in_ready);
    end else if (sb) begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    in_if.in_valid = 1'b0;
    in_if.in_instr = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    vec_t        tbl[10];
    int          st;
    int          tot;
    int          bp_st[7];
    logic [17:0] bp_ins[7];
    logic [17:0] ins;
    logic [2:0]  m_op[4];
    logic        m_wr[4];

    tbl[0] = '{ldi(3'd0, 12'd5),            pk(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 12'd5),  1};
    tbl[1] = '{ldi(3'd1, 12'd3),            pk(3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 12'd3),  1};
    tbl[2] = '{alu(3'd1, 3'd2, 3'd0, 3'd1, 6'h00), pk(3'd1, 3'd2, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 12'd0), 1};
    tbl[3] = '{alu(3'd2, 3'd3, 3'd0, 3'd1, 6'h00), pk(3'd2, 3'd3, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 12'd0), 1};
    tbl[4] = '{alu(3'd3, 3'd4, 3'd0, 3'd1, 6'h00), pk(3'd3, 3'd4, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 12'd0), MUL_LAT};
    tbl[5] = '{alu(3'd4, 3'd5, 3'd6, 3'd7, 6'h3F), pk(3'd4, 3'd5, 3'd6, 3'd7, 1'b1, 1'b1, 1'b0, 12'd0), MUL_LAT};
    tbl[6] = '{alu(3'd5, 3'd6, 3'd2, 3'd3, 6'h2A), pk(3'd5, 3'd6, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 12'd0), 1};
    tbl[7] = '{alu(3'd6, 3'd7, 3'd1, 3'd2, 6'h00), pk(3'd6, 3'd7, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 12'd0), MUL_LAT};
    tbl[8] = '{alu(3'd7, 3'd1, 3'd7, 3'd0, 6'h15), pk(3'd7, 3'd1, 3'd7, 3'd0, 1'b1, 1'b1, 1'b0, 12'd0), 1};
    tbl[9] = '{ldi(3'd7, 12'hFFF),          pk(3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 12'hFFF), 1};

    // reset held two cycles with in_valid high
    rst = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_instr = ldi(3'd0, 12'd5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_if.in_ready, 0);
    check("rst_outs", obs, 0);
    check("rst_write", write, 0);
    check("rst_busy", busy, 0);
    check("rst_retired", retired, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    check("post_rst_in_ready", in_if.in_ready, 1);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // table: one instruction at a time, cycle-exact line and write checks
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].instr, tbl[i].exp, 1'b1, st);
      idle_in();
      @(negedge clk);
      check($sformatf("v%0d_queued_write", i), write, 0);
      check($sformatf("v%0d_queued_busy", i), busy, 1);
      for (int k = 1; k <= tbl[i].lat; k++) begin
        @(negedge clk);
        check($sformatf("v%0d_c%0d_lines", i, k), obs, tbl[i].exp);
        check($sformatf("v%0d_c%0d_write", i, k), write, (k == tbl[i].lat) ? 1 : 0);
      end
      @(negedge clk);
      exp_ret++;
      check($sformatf("v%0d_done_busy", i), busy, 0);
      check($sformatf("v%0d_done_write", i), write, 0);
      check($sformatf("v%0d_retired", i), retired, 8'(exp_ret));
      @(posedge clk); #1;
    end

    // back-to-back loads
    send(ldi(3'd0, 12'd5), model(ldi(3'd0, 12'd5)), 1'b1, st);
    send(ldi(3'd1, 12'd3), model(ldi(3'd1, 12'd3)), 1'b1, st);
    idle_in();
    @(negedge clk);
    check("ld1_lines", obs, pk(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 12'd5));
    check("ld1_write", write, 1);
    @(negedge clk);
    check("ld2_lines", obs, pk(3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 12'd3));
    check("ld2_write", write, 1);
    @(negedge clk);
    exp_ret += 2;
    check("ld_busy", busy, 0);
    check("ld_retired", retired, 8'(exp_ret));
    @(posedge clk); #1;

    // ADD then SUB
    send(alu(3'd1, 3'd2, 3'd0, 3'd1, 6'h00), model(alu(3'd1, 3'd2, 3'd0, 3'd1, 6'h00)), 1'b1, st);
    send(alu(3'd2, 3'd3, 3'd0, 3'd1, 6'h00), model(alu(3'd2, 3'd3, 3'd0, 3'd1, 6'h00)), 1'b1, st);
    idle_in();
    @(negedge clk);
    check("add_lines", obs, pk(3'd1, 3'd2, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 12'd0));
    check("add_write", write, 1);
    @(negedge clk);
    check("sub_lines", obs, pk(3'd2, 3'd3, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 12'd0));
    check("sub_write", write, 1);
    @(negedge clk);
    exp_ret += 2;
    check("alu_busy", busy, 0);
    check("alu_retired", retired, 8'(exp_ret));
    @(posedge clk); #1;

    // MUL followed by ADD with no bubble
    m_op[0] = 3'd3; m_op[1] = 3'd3; m_op[2] = 3'd3; m_op[3] = 3'd1;
    m_wr[0] = 1'b0; m_wr[1] = 1'b0; m_wr[2] = 1'b1; m_wr[3] = 1'b1;
    send(alu(3'd3, 3'd4, 3'd0, 3'd1, 6'h00), model(alu(3'd3, 3'd4, 3'd0, 3'd1, 6'h00)), 1'b1, st);
    send(alu(3'd1, 3'd2, 3'd0, 3'd1, 6'h00), model(alu(3'd1, 3'd2, 3'd0, 3'd1, 6'h00)), 1'b1, st);
    idle_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mul_c%0d_opcode", k), opcode, m_op[k]);
      check($sformatf("mul_c%0d_write", k), write, m_wr[k]);
    end
    @(negedge clk);
    exp_ret += 2;
    check("mul_busy", busy, 0);
    check("mul_retired", retired, 8'(exp_ret));
    @(posedge clk); #1;

    // backpressure: FIFO fills behind long ops; full blocks push even on a pop cycle
    bp_ins[0] = alu(3'd3, 3'd4, 3'd0, 3'd1, 6'h00);
    bp_ins[1] = alu(3'd3, 3'd5, 3'd1, 3'd2, 6'h00);
    bp_ins[2] = alu(3'd4, 3'd6, 3'd2, 3'd3, 6'h00);
    bp_ins[3] = alu(3'd1, 3'd1, 3'd4, 3'd5, 6'h00);
    bp_ins[4] = alu(3'd2, 3'd2, 3'd5, 3'd6, 6'h00);
    bp_ins[5] = alu(3'd5, 3'd3, 3'd6, 3'd7, 6'h00);
    bp_ins[6] = alu(3'd7, 3'd0, 3'd7, 3'd0, 6'h00);
    for (int i = 0; i < 7; i++) send(bp_ins[i], model(bp_ins[i]), 1'b1, bp_st[i]);
    idle_in();
    for (int i = 1; i < 6; i++) check($sformatf("bp_stall%0d", i), bp_st[i], 0);
    check("bp_stall6", bp_st[6], 2);
    wait_idle();
    exp_ret += 7;
    check("bp_retired", retired, 8'(exp_ret));

    // retired wrap from a fresh reset, with continuous single-cycle loads
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    check("wrap_rst_retired", retired, 0);
    @(posedge clk); #1;
    tot = 0;
    for (int i = 0; i < 255; i++) begin
      ins = ldi(3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
      send(ins, model(ins), 1'b1, st);
      tot += st;
    end
    idle_in();
    wait_idle();
    check("wrap_no_stalls", tot, 0);
    check("wrap_retired255", retired, 8'd255);
    ins = ldi(3'd2, 12'hABC);
    send(ins, model(ins), 1'b1, st);
    idle_in();
    wait_idle();
    check("wrap_retired0", retired, 8'd0);

    // abort: reset on the 2nd cycle of a MUL with a load queued behind it
    send(alu(3'd3, 3'd4, 3'd0, 3'd1, 6'h00), '0, 1'b0, st);
    send(ldi(3'd7, 12'h123), '0, 1'b0, st);
    idle_in();
    @(negedge clk);
    check("abort_c1_opcode", opcode, 3'd3);
    check("abort_c1_state", dbg_state, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_c2_write", write, 0);
    check("abort_in_ready", in_if.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_outs", obs, 0);
    check("abort_write", write, 0);
    check("abort_busy", busy, 0);
    check("abort_retired", retired, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", k), {busy, write}, 0);
    end

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
